// File: rtl/sobel_ctrl_pkg.sv
// Shared types for the sobel stream controller.
// Line payload type and controller state encoding.
package sobel_ctrl_pkg;

    localparam int LINE_BITS = 512;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sobel_ctrl_fifo.sv
// Synchronous FIFO for datapath results.
// A push into a full FIFO only lands when a pop frees a slot.
module sobel_ctrl_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer around the sobel datapath: credit-limited line
// reads in, FIFO-buffered line writes out.
module sobel_stream_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int LINE_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DP_LAT     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LINE_W-1:0] num_lines,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [LINE_W-1:0] rd_req_idx,
    input  logic              rd_rsp_valid,
    input  line_t             rd_rsp_data,
    output line_t             dp_data_in,
    output logic              dp_valid_in,
    input  line_t             dp_data_out,
    input  logic              dp_valid_out,
    output logic              wr_req_valid,
    input  logic              wr_req_ready,
    output logic [LINE_W-1:0] wr_req_idx,
    output line_t             wr_req_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (DP_LAT < 1) begin : g_bad_lat
        $error("DP_LAT must be positive");
    end

    state_t            state_q;
    state_t            state_d;
    logic [LINE_W-1:0] num_q;
    logic [LINE_W-1:0] rd_cnt;
    logic [LINE_W-1:0] wr_cnt;
    logic [CW-1:0]     credits;

    logic  start_ok;
    logic  rd_fire;
    logic  wr_fire;
    logic  rd_last;
    logic  wr_last;
    logic  rsp_ok;
    logic  rsp_bad;
    logic  push_drop;
    logic  fifo_full;
    logic  fifo_empty;
    line_t fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign rd_fire   = rd_req_valid && rd_req_ready;
    assign wr_fire   = wr_req_valid && wr_req_ready;
    assign rd_last   = (rd_cnt == num_q - 1'b1);
    assign wr_last   = (wr_cnt == num_q - 1'b1);
    assign rsp_ok    = rd_rsp_valid && busy;
    assign rsp_bad   = rd_rsp_valid && !busy;
    assign push_drop = dp_valid_out && fifo_full && !wr_fire;

    assign rd_req_idx   = rd_cnt;
    assign wr_req_idx   = wr_cnt;
    assign wr_req_valid = (fifo_count != '0);
    assign wr_req_data  = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (num_lines == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_fire && rd_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_fire && wr_last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        rd_req_valid = 1'b0;
        unique case (state_q)
            RUN: begin
                busy         = 1'b1;
                rd_req_valid = (credits != '0);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q       <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            credits     <= CRED_MAX;
            error       <= 1'b0;
            dp_valid_in <= 1'b0;
            dp_data_in  <= '0;
        end else begin
            if (start_ok) begin
                num_q  <= num_lines;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_fire) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (wr_fire) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // Saturate so stray writes cannot lift credits past depth.
            unique case ({rd_fire, wr_fire})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits != CRED_MAX) begin
                        credits <= credits + 1'b1;
                    end
                end
                default: credits <= credits;
            endcase
            dp_valid_in <= rsp_ok;
            if (rsp_ok) begin
                dp_data_in <= rd_rsp_data;
            end
            if (rsp_bad || push_drop) begin
                error <= 1'b1;
            end
        end
    end

    sobel_ctrl_fifo #(
        .WIDTH (LINE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dp_valid_out),
        .pop   (wr_fire),
        .din   (dp_data_out),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
